// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the 8N1 UART receive front end.
package uart_rx_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int DATA_BITS  = 8;
endpackage

// File: rtl/byte_fifo.sv
// First-word fall-through byte FIFO with registered head; push lands 1 cycle after i_push_vld.
// A push into a full FIFO is dropped (o_drop pulse) unless a pop frees the slot in the same cycle.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push_vld,
  input  logic [7:0]               i_push_dat,
  input  logic                     i_pop_rdy,
  output logic [7:0]               o_dat,
  output logic                     o_vld,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_dat;
  logic          r_drop;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [7:0]    w_dat_nxt;
  logic          w_full;
  logic          w_pop;
  logic          w_wr_en;

  assign w_pop        = (r_level != '0) && i_pop_rdy;
  assign w_full       = (r_level == (AW+1)'(DEPTH));
  assign w_wr_en      = i_push_vld && (!w_full || w_pop);
  assign w_rd_ptr_nxt = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;

  // The new head is the incoming byte only when it lands on the slot the read pointer moves to.
  always_comb begin
    w_dat_nxt = r_mem[w_rd_ptr_nxt];
    if (w_wr_en && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_dat_nxt = i_push_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_dat    <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      case ({w_wr_en, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
      r_dat  <= w_dat_nxt;
      r_drop <= i_push_vld && w_full && !w_pop;
    end
  end

  assign o_dat   = r_dat;
  assign o_vld   = (r_level != '0);
  assign o_level = r_level;
  assign o_drop  = r_drop;
endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (16x oversampled) feeding a FWFT byte FIFO on a valid/ready stream.
// m_valid rises 2 cycles after the stop-bit sample; bytes completing while full are dropped.
module uart_rx_fifo #(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rxd,
  input  logic [DIV_W-1:0]              baud_div,
  output logic [7:0]                    m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import uart_rx_pkg::*;

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BI_W = $clog2(DATA_BITS);

  logic                 r_sync1;
  logic                 r_rx_s;
  logic                 r_rx_d;
  logic [DIV_W-1:0]     r_tick_cnt;
  rx_state_t            r_state;
  rx_state_t            w_state_nxt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [BI_W-1:0]      r_bit_idx;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_push;
  logic                 r_frame_err;
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_bit_end;
  logic                 w_os_clr;
  logic                 w_shift;
  logic                 w_stop_ok;
  logic                 w_stop_bad;

  assign w_tick    = (r_tick_cnt == '0);
  assign w_mid     = w_tick && (r_os_cnt == OS_W'(MID_SAMPLE));
  assign w_bit_end = w_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1    <= 1'b1;
      r_rx_s     <= 1'b1;
      r_rx_d     <= 1'b1;
      r_tick_cnt <= '0;
    end else begin
      r_sync1    <= rxd;
      r_rx_s     <= r_sync1;
      r_rx_d     <= r_rx_s;
      r_tick_cnt <= w_tick ? baud_div : r_tick_cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_clr    = 1'b0;
    w_shift     = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_rx_d && !r_rx_s) begin
          w_state_nxt = START;
          w_os_clr    = 1'b1;
        end
      end
      START: begin
        // Re-centre the bit counter on mid-start so later samples land mid-bit.
        if (w_mid) begin
          if (!r_rx_s) begin
            w_state_nxt = DATA;
            w_os_clr    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_shift = 1'b1;
          if (r_bit_idx == BI_W'(DATA_BITS - 1)) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_stop_ok   = r_rx_s;
          w_stop_bad  = !r_rx_s;
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shreg     <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_os_clr) begin
        r_os_cnt <= '0;
      end else if (w_tick && (r_state != IDLE)) begin
        r_os_cnt <= r_os_cnt + OS_W'(1);
      end
      if (w_os_clr) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_bit_idx <= r_bit_idx + BI_W'(1);
      end
      if (w_shift) begin
        r_shreg <= {r_rx_s, r_shreg[DATA_BITS-1:1]};
      end
      r_push      <= w_stop_ok;
      r_frame_err <= w_stop_bad;
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (r_push),
    .i_push_dat (r_shreg),
    .i_pop_rdy  (m_ready),
    .o_dat      (m_data),
    .o_vld      (m_valid),
    .o_level    (fifo_level),
    .o_drop     (overrun)
  );

  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: vector table of frames plus hand-written corner sequences.
module tb_uart_rx_fifo;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        frame_err;
  logic        overrun;
  logic [2:0]  fifo_level;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .DIV_W      (16),
    .FIFO_DEPTH (4),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .baud_div   (baud_div),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .fifo_level (fifo_level)
  );

  typedef struct {
    int         div;
    int         rdy;
    logic [7:0] dat;
    int         stop;
    int         accept;
    int         fe;
    int         ov;
    int         lvl;
    int         drain;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         both_cnt = 0;
  int         bit_clks = 64;
  logic [7:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop);
    rxd = 1'b0;
    tick_clk(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      tick_clk(bit_clks);
    end
    rxd = (stop != 0);
    tick_clk(bit_clks);
    rxd = 1'b1;
  endtask

  task automatic set_baud(input int div);
    baud_div = 16'(div);
    bit_clks = 16 * (div + 1);
    tick_clk(8);
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) begin
      tick_clk(1);
    end
    tick_clk(2);
    chk({tag, "_drain_queue"}, exp_q.size(), 0);
    chk({tag, "_drain_level"}, int'(fifo_level), 0);
  endtask

  // Scoreboard consumer and pulse counters, sampled on the falling edge.
  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun) ov_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (!rst && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", int'(m_data), 256);
      end else begin
        chk("pop_data", int'(m_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [11];
    int   fe0;
    int   ov0;
    int   n;
    int   lvl_at_pop;

    vecs[0]  = '{3, 1, 8'hA5, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 8'h00, 1, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 8'hFF, 1, 1, 0, 0, 2, 0};
    vecs[3]  = '{0, 0, 8'h3C, 1, 1, 0, 0, 3, 1};
    vecs[4]  = '{0, 0, 8'h01, 1, 1, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 8'h02, 1, 1, 0, 0, 2, 0};
    vecs[6]  = '{0, 0, 8'h03, 1, 1, 0, 0, 3, 0};
    vecs[7]  = '{0, 0, 8'h04, 1, 1, 0, 0, 4, 0};
    vecs[8]  = '{0, 0, 8'h05, 1, 0, 0, 1, 4, 1};
    vecs[9]  = '{0, 1, 8'h55, 0, 0, 1, 0, 0, 0};
    vecs[10] = '{0, 1, 8'h66, 1, 1, 0, 0, 0, 0};

    tick_clk(3);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_level", int'(fifo_level), 0);
    rst = 1'b0;
    tick_clk(4);

    for (int i = 0; i < 11; i++) begin
      m_ready = (vecs[i].rdy != 0);
      set_baud(vecs[i].div);
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      if (vecs[i].accept != 0) exp_q.push_back(vecs[i].dat);
      send_byte(vecs[i].dat, vecs[i].stop);
      tick_clk(6);
      chk($sformatf("v%0d_frame_err", i), fe_cnt - fe0, vecs[i].fe);
      chk($sformatf("v%0d_overrun", i), ov_cnt - ov0, vecs[i].ov);
      chk($sformatf("v%0d_level", i), int'(fifo_level), vecs[i].lvl);
      if (vecs[i].lvl > 0) begin
        chk($sformatf("v%0d_head", i), int'(m_data), int'(exp_q[0]));
      end
      if (vecs[i].drain != 0) drain($sformatf("v%0d", i));
    end

    // Full FIFO: time a single-cycle pop to coincide with the incoming push.
    m_ready = 1'b0;
    set_baud(0);
    exp_q.push_back(8'hC0);
    n = 0;
    fork
      send_byte(8'hC0, 1);
      begin
        while (!m_valid && n < 400) begin
          @(negedge clk);
          n++;
        end
      end
    join
    chk("calib_valid", int'(m_valid), 1);
    tick_clk(6);
    for (int i = 1; i < 4; i++) begin
      exp_q.push_back(8'hC0 + 8'(i));
      send_byte(8'hC0 + 8'(i), 1);
      tick_clk(6);
    end
    chk("full_level", int'(fifo_level), 4);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    exp_q.push_back(8'hC4);
    lvl_at_pop = 0;
    fork
      send_byte(8'hC4, 1);
      begin
        repeat (n - 2) @(posedge clk);
        #1 m_ready = 1'b1;
        @(posedge clk);
        #1 m_ready = 1'b0;
        lvl_at_pop = int'(fifo_level);
      end
    join
    chk("simul_level_at_pop", lvl_at_pop, 4);
    tick_clk(6);
    chk("simul_level", int'(fifo_level), 4);
    chk("simul_overrun", ov_cnt - ov0, 0);
    chk("simul_head", int'(m_data), 8'hC1);
    drain("simul");

    // Short low glitch must be rejected at mid-start.
    m_ready = 1'b1;
    set_baud(3);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd = 1'b0;
    tick_clk(4);
    rxd = 1'b1;
    tick_clk(150);
    chk("glitch_level", int'(fifo_level), 0);
    chk("glitch_valid", int'(m_valid), 0);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_overrun", ov_cnt - ov0, 0);
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1);
    tick_clk(6);
    chk("glitch_after_queue", exp_q.size(), 0);

    // Reset in the middle of bit 4 of 0x81, then a clean 0x42.
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rxd = 1'b0;
    tick_clk(bit_clks);
    for (int i = 0; i < 4; i++) begin
      rxd = (i == 0);
      tick_clk(bit_clks);
    end
    rxd = 1'b0;
    tick_clk(bit_clks / 2);
    rst = 1'b1;
    tick_clk(2);
    chk("midrst_m_valid", int'(m_valid), 0);
    chk("midrst_m_data", int'(m_data), 0);
    chk("midrst_frame_err", int'(frame_err), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_level", int'(fifo_level), 0);
    rxd = 1'b1;
    tick_clk(10);
    rst = 1'b0;
    tick_clk(20);
    exp_q.push_back(8'h42);
    send_byte(8'h42, 1);
    tick_clk(6);
    chk("midrst_queue", exp_q.size(), 0);
    chk("midrst_frame_err_cnt", fe_cnt - fe0, 0);
    chk("midrst_overrun_cnt", ov_cnt - ov0, 0);
    chk("midrst_level_end", int'(fifo_level), 0);

    chk("both_pulses", both_cnt, 0);
    chk("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
